// File: rtl/im_loader.sv
// im_loader: streams 32-bit instruction words from a valid/ready host into a
// byte-wide, big-endian instruction memory. Each accepted word becomes four
// consecutive byte writes, MSB first, so a later fetch of IM[a..a+3] returns
// the original word.
module im_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,  // must equal 2**ADDR_W
    parameter int unsigned BASE_ADDR = 0     // must be a multiple of 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              mem_full,
    output logic [ADDR_W-2:0] words_loaded
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StWrite,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [31:0]         shift_q, shift_d;
    logic                last_q, last_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [ADDR_W-2:0]   words_q, words_d;
    logic                full_q, full_d;

    // State and datapath registers; async reset returns to idle at BASE_ADDR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            ptr_q      <= BaseAddr;
            shift_q    <= '0;
            last_q     <= 1'b0;
            byte_idx_q <= 2'd0;
            words_q    <= '0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            byte_idx_q <= byte_idx_d;
            words_q    <= words_d;
            full_q     <= full_d;
        end
    end

    // Next-state logic: accept a word, emit its four bytes, then decide whether
    // the session ends (last word or memory exhausted) or waits for another.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        shift_d    = shift_q;
        last_d     = last_q;
        byte_idx_d = byte_idx_q;
        words_d    = words_q;
        full_d     = full_q;

        case (state_q)
            StIdle, StDone: begin
                // in_ready is low here, so a coincident in_valid is not taken.
                if (start) begin
                    state_d = StAccept;
                    ptr_d   = BaseAddr;
                    words_d = '0;
                    full_d  = 1'b0;
                end
            end

            StAccept: begin
                if (in_valid) begin
                    shift_d    = in_word;
                    last_d     = in_last;
                    byte_idx_d = 2'd0;
                    state_d    = StWrite;
                end
            end

            StWrite: begin
                // Pointer wraps naturally at 2**ADDR_W.
                ptr_d      = ptr_q + 1'b1;
                shift_d    = {shift_q[23:0], 8'h00};
                byte_idx_d = byte_idx_q + 1'b1;
                if (byte_idx_q == 2'd3) begin
                    words_d = words_q + 1'b1;
                    if (last_q) begin
                        state_d = StDone;
                        full_d  = 1'b0;
                    end else if (ptr_q == LastAddr) begin
                        state_d = StDone;
                        full_d  = 1'b1;
                    end else begin
                        state_d = StAccept;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded only from registered state; no input reaches an output
    // combinationally.
    always_comb begin
        in_ready     = (state_q == StAccept);
        mem_we       = (state_q == StWrite);
        mem_addr     = mem_we ? ptr_q : '0;
        mem_wdata    = mem_we ? shift_q[31:24] : 8'h00;
        busy         = (state_q == StAccept) || (state_q == StWrite);
        done         = (state_q == StDone);
        mem_full     = full_q;
        words_loaded = words_q;
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: a scoreboard of expected (address, byte) writes
// is filled when a word is handed over and drained as mem_we strobes appear.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        in_last = 1'b0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        mem_full;
    logic [6:0]  words_loaded;

    im_loader #(
        .ADDR_W    (8),
        .DEPTH     (256),
        .BASE_ADDR (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
        .in_last      (in_last),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .mem_full     (mem_full),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          first_acc = 0;
    int          done_cyc = 0;
    logic [7:0]  exp_ptr = 8'h00;
    logic [7:0]  last_wr_addr = 8'h00;
    logic [15:0] sb[$];
    logic [7:0]  tbmem[256];

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory model.
    always @(posedge clk) begin
        if (mem_we) tbmem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_we) begin
            logic [15:0] e;
            chk("write_expected", 32'(sb.size() > 0), 32'd1);
            chk("ready_low_in_write", in_ready, 1'b0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_addr", mem_addr, e[15:8]);
                chk("wr_data", mem_wdata, e[7:0]);
            end
            last_wr_addr = mem_addr;
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input logic last, input bit drop);
        int t = 0;
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                chk("accept_timeout", in_ready, 1'b1);
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({exp_ptr, w[31-8*i -: 8]});
            exp_ptr = exp_ptr + 8'd1;
        end
        if (drop) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        done_cyc = cyc;
        chk(tag, done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_wdata", mem_wdata, 8'h00);
        chk("rst_busy_done_full", {busy, done, mem_full}, 3'b000);
        chk("rst_words", words_loaded, 7'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single word.
        pulse_start();
        chk("start_busy", busy, 1'b1);
        chk("start_ready", in_ready, 1'b1);
        exp_ptr = 8'h00;
        send(32'hF8420005, 1'b1, 1'b1);
        wait_done("single_done");
        chk("single_words", words_loaded, 7'd1);
        chk("single_full", mem_full, 1'b0);
        chk("single_sb_empty", sb.size(), 0);
        chk("single_mem", {tbmem[0], tbmem[1], tbmem[2], tbmem[3]}, 32'hF8420005);

        // Four-word program with in_valid held; 20 cycles including the
        // accepting one, so done rises 19 edges after the first accept.
        pulse_start();
        chk("restart_done_low", done, 1'b0);
        exp_ptr = 8'h00;
        send(32'hF8420005, 1'b0, 1'b0);
        first_acc = acc_cyc;
        send(32'hF845000A, 1'b0, 1'b0);
        send(32'h8B0A00A1, 1'b0, 1'b0);
        send(32'hCB0A00A2, 1'b1, 1'b1);
        wait_done("prog_done");
        chk("prog_latency", done_cyc - first_acc, 19);
        chk("prog_words", words_loaded, 7'd4);
        chk("prog_sb_empty", sb.size(), 0);
        chk("prog_mem_c", {tbmem[12], tbmem[13], tbmem[14], tbmem[15]}, 32'hCB0A00A2);

        // Back-pressure; stray in_last and start while waiting are ignored.
        pulse_start();
        exp_ptr = 8'h00;
        send(32'h11223344, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_ready", in_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_last = 1'b1;
            start   = (i == 3);
            @(negedge clk);
            chk("bp_no_we", mem_we, 1'b0);
            chk("bp_ready_hold", in_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        in_last = 1'b0;
        send(32'h8A0A00A3, 1'b1, 1'b1);
        wait_done("bp_done");
        chk("bp_words", words_loaded, 7'd2);
        chk("bp_mem", {tbmem[4], tbmem[5], tbmem[6], tbmem[7]}, 32'h8A0A00A3);

        // Full memory: 64 words without in_last.
        pulse_start();
        exp_ptr = 8'h00;
        for (int i = 0; i < 64; i++) begin
            send({8'(i), 8'(~i), 8'(i * 3), 8'hA5}, 1'b0, 1'b0);
        end
        wait_done("full_done");
        chk("full_flag", mem_full, 1'b1);
        chk("full_words", words_loaded, 7'd64);
        chk("full_last_addr", last_wr_addr, 8'hFF);
        chk("full_mem_top", {tbmem[252], tbmem[253], tbmem[254], tbmem[255]}, 32'h3FC0BDA5);
        repeat (10) @(posedge clk);
        #1;
        chk("full_no_65th", in_ready, 1'b0);
        chk("full_sb_empty", sb.size(), 0);

        // Restart from DONE with in_valid already high: not taken on the start edge.
        in_valid = 1'b1;
        in_word  = 32'h12345678;
        in_last  = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("rs_done_drop", done, 1'b0);
        chk("rs_full_clear", mem_full, 1'b0);
        chk("rs_words_clear", words_loaded, 7'd0);
        chk("rs_no_write", mem_we, 1'b0);
        exp_ptr = 8'h00;
        send(32'h12345678, 1'b1, 1'b1);
        wait_done("rs_done");
        chk("rs_words", words_loaded, 7'd1);
        chk("rs_mem", {tbmem[0], tbmem[1], tbmem[2], tbmem[3]}, 32'h12345678);

        // Reset during the second byte of a word.
        pulse_start();
        exp_ptr = 8'h00;
        send(32'hAABBCCDD, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("mid_we_before", mem_we, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", mem_we, 1'b0);
        chk("mid_rst_addr_data", {mem_addr, mem_wdata}, 16'h0000);
        chk("mid_rst_flags", {in_ready, busy, done, mem_full}, 4'b0000);
        chk("mid_rst_words", words_loaded, 7'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_aa_written", tbmem[0], 8'hAA);
        chk("mid_bb_absent", tbmem[1], 8'h34);
        pulse_start();
        chk("mid_words_zero", words_loaded, 7'd0);
        exp_ptr = 8'h00;
        send(32'h0BADF00D, 1'b1, 1'b1);
        wait_done("mid_done");
        chk("mid_words", words_loaded, 7'd1);
        chk("mid_mem", {tbmem[0], tbmem[1], tbmem[2], tbmem[3]}, 32'h0BADF00D);
        chk("mid_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
